accumulator_12bit_stream: RTL and testbench

// - Streaming signed accumulator: the summing counterpart of the 12-bit two's-complement subtractor. Sums a

---
 rtl/acc_pkg.sv | 18 +
 rtl/accumulator_12bit_stream_addsub.sv | 44 ++++
 rtl/accumulator_12bit_stream.sv | 120 ++++++++++++
 tb/tb_accumulator_12bit_stream.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and defaults for the streaming signed accumulator.
// SAT_MAX/SAT_MIN are the clamp limits at the default accumulator width.
package acc_pkg;

  localparam int unsigned DEF_WIDTH   = 12;
  localparam int unsigned DEF_ACC_W   = 16;
  localparam int unsigned DEF_MAX_LEN = 16;

  localparam logic [DEF_ACC_W-1:0] SAT_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic [DEF_ACC_W-1:0] SAT_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/accumulator_12bit_stream_addsub.sv
// Combinational ACC_W-bit signed add/subtract with overflow detection.
// Define SATURATE_EN to clamp the sum on overflow instead of wrapping.
module addsub_ovf #(
  parameter int unsigned ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             sub,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  // Two guard bits hold the exact result, including negation of the most negative value.
  localparam int unsigned WW = ACC_W + 2;
  localparam logic [ACC_W-1:0] MIN_VAL = {1'b1, {(ACC_W-1){1'b0}}};
`ifdef SATURATE_EN
  localparam logic [ACC_W-1:0] SAT_HI = {1'b0, {(ACC_W-1){1'b1}}};
`endif

  logic [WW-1:0] a_w;
  logic [WW-1:0] b_w;
  logic [WW-1:0] wide;
  logic          neg_ovf;
  logic          fit_ovf;

  always_comb begin
    a_w     = WW'($signed(a));
    b_w     = WW'($signed(b));
    wide    = sub ? (a_w + ~b_w + WW'(1)) : (a_w + b_w);
    neg_ovf = sub && (b == MIN_VAL);
    fit_ovf = (wide[WW-1:ACC_W-1] != '0) && (wide[WW-1:ACC_W-1] != '1);
    ovf     = neg_ovf | fit_ovf;
`ifdef SATURATE_EN
    if (fit_ovf) begin
      sum = wide[WW-1] ? MIN_VAL : SAT_HI;
    end else begin
      sum = wide[ACC_W-1:0];
    end
`else
    sum = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/accumulator_12bit_stream.sv
// Streaming signed accumulator: sums a packet of add/sub operands, one result per packet.
// Optional clamping on overflow via SATURATE_EN (handled in addsub_ovf).
module accumulator_12bit_stream
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned ACC_W   = DEF_ACC_W,
  parameter int unsigned MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  acc_state_t state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [ACC_W-1:0] out_sum_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_ovf_q;

  logic [ACC_W-1:0] opnd_c;
  logic [ACC_W-1:0] sum_c;
  logic             ovf_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             accept_c;
  logic             closing_c;
  logic             release_c;

  assign opnd_c    = ACC_W'($signed(in_data));
  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign accept_c  = in_valid & in_ready_q;
  assign closing_c = accept_c & (in_last | (cnt_inc_c == CNT_W'(MAX_LEN)));
  assign release_c = out_valid_q & out_ready;

  addsub_ovf #(.ACC_W(ACC_W)) u_addsub (
    .a   (acc_q),
    .b   (opnd_c),
    .sub (in_sub),
    .sum (sum_c),
    .ovf (ovf_c)
  );

  // State register plus the handshake flags decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ACCUM;
      ACCUM:   if (closing_c) state_d = DONE;
      DONE:    if (out_ready) state_d = ACCUM;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    if (state_d == ACCUM) in_ready_d = 1'b1;
    if (state_d == DONE)  out_valid_d = 1'b1;
  end

  // Running total clears only once the result has been taken downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (accept_c) begin
        acc_q <= sum_c;
        cnt_q <= cnt_inc_c;
        ovf_q <= ovf_q | ovf_c;
      end else if (release_c) begin
        acc_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end
      if (closing_c) begin
        out_sum_q   <= sum_c;
        out_count_q <= cnt_inc_c;
        out_ovf_q   <= ovf_q | ovf_c;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_accumulator_12bit_stream.sv
// Directed bench for accumulator_12bit_stream: default 16-bit instance plus a 12-bit
// accumulator instance for overflow cases; expectations follow SATURATE_EN.
module tb_accumulator_12bit_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_sub;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_sum;
  logic [4:0]  out_count;

  logic        in_ready12, out_valid12, out_ovf12;
  logic [11:0] out_sum12;
  logic [4:0]  out_count12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accumulator_12bit_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  accumulator_12bit_stream #(.WIDTH(12), .ACC_W(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready12),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(out_valid12), .out_ready(out_ready), .out_sum(out_sum12),
    .out_count(out_count12), .out_ovf(out_ovf12)
  );

  // Present one beat from the negedge, bounded wait for in_ready.
  task automatic send_beat(input logic [11:0] d, input logic s, input logic l);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL beat_wait in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_data = d; in_sub = s; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 12'hABC; in_sub = 1'b1; in_last = 1'b1;
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 16'h0 || out_count !== 5'd0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b sum=%h cnt=%0d ovf=%b required 0 0 0000 0 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    send_beat(12'd5, 1'b0, 1'b0);
    send_beat(12'd7, 1'b0, 1'b0);
    send_beat(12'hFFD, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency got vld=%b rdy=%b required 1 0", out_valid, in_ready);
    end
    checks++;
    if (out_sum !== 16'd9 || out_count !== 5'd3 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got sum=%h cnt=%0d ovf=%b required 0009 3 0", out_sum, out_count, out_ovf);
    end
    take_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release got vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_subtract();
    send_beat(12'd100, 1'b0, 1'b0);
    send_beat(12'd250, 1'b1, 1'b0);
    send_beat(12'd4, 1'b1, 1'b1);
    checks++;
    if (out_sum !== 16'hFF66 || out_count !== 5'd3 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL subtract_result got sum=%h cnt=%0d ovf=%b required ff66 3 0", out_sum, out_count, out_ovf);
    end
    take_result();
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 15; i++) send_beat(12'd2047, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL maxlen_early_close got vld=%b required 0", out_valid);
    end
    send_beat(12'd2047, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'd32752 || out_count !== 5'd16 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL maxlen_result got vld=%b sum=%0d cnt=%0d ovf=%b required 1 32752 16 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL maxlen_hold got rdy=%b vld=%b required 0 1", in_ready, out_valid);
    end
    take_result();
  endtask

  task automatic test_overflow();
    logic [11:0] exp_a, exp_b, exp_c;
`ifdef SATURATE_EN
    exp_a = 12'h7FF; exp_b = 12'h7FE; exp_c = 12'h7FF;
`else
    exp_a = 12'h800; exp_b = 12'h7FF; exp_c = 12'h800;
`endif
    send_beat(12'd2047, 1'b0, 1'b0);
    send_beat(12'd1, 1'b0, 1'b1);
    checks++;
    if (out_sum12 !== exp_a || out_ovf12 !== 1'b1 || out_count12 !== 5'd2) begin
      errors++;
      $display("FAIL ovf12_result got sum=%h ovf=%b cnt=%0d required %h 1 2", out_sum12, out_ovf12, out_count12, exp_a);
    end
    checks++;
    if (out_sum !== 16'h0800 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf16_no_wrap got sum=%h ovf=%b required 0800 0", out_sum, out_ovf);
    end
    take_result();
    send_beat(12'd2047, 1'b0, 1'b0);
    send_beat(12'd1, 1'b0, 1'b0);
    send_beat(12'hFFF, 1'b0, 1'b1);
    checks++;
    if (out_sum12 !== exp_b || out_ovf12 !== 1'b1) begin
      errors++;
      $display("FAIL ovf12_sticky got sum=%h ovf=%b required %h 1", out_sum12, out_ovf12, exp_b);
    end
    checks++;
    if (out_sum !== 16'h07FF || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf16_sticky_case got sum=%h ovf=%b required 07ff 0", out_sum, out_ovf);
    end
    take_result();
    send_beat(12'h800, 1'b1, 1'b1);
    checks++;
    if (out_sum12 !== exp_c || out_ovf12 !== 1'b1 || out_count12 !== 5'd1) begin
      errors++;
      $display("FAIL ovf12_negate_min got sum=%h ovf=%b cnt=%0d required %h 1 1", out_sum12, out_ovf12, out_count12, exp_c);
    end
    checks++;
    if (out_sum !== 16'h0800 || out_ovf !== 1'b0 || out_count !== 5'd1) begin
      errors++;
      $display("FAIL ovf16_negate_min got sum=%h ovf=%b cnt=%0d required 0800 0 1", out_sum, out_ovf, out_count);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    send_beat(12'd3, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'd3 || out_count !== 5'd1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d] got vld=%b sum=%h cnt=%0d rdy=%b required 1 0003 1 0",
                 i, out_valid, out_sum, out_count, in_ready);
      end
    end
    take_result();
    send_beat(12'd10, 1'b0, 1'b1);
    checks++;
    if (out_sum !== 16'd10 || out_count !== 5'd1) begin
      errors++;
      $display("FAIL backpressure_next got sum=%h cnt=%0d required 000a 1", out_sum, out_count);
    end
    take_result();
  endtask

  task automatic test_idle_gap();
    send_beat(12'd7, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_gap_hold got vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    send_beat(12'd8, 1'b0, 1'b1);
    checks++;
    if (out_sum !== 16'd15 || out_count !== 5'd2) begin
      errors++;
      $display("FAIL idle_gap_result got sum=%h cnt=%0d required 000f 2", out_sum, out_count);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    send_beat(12'd50, 1'b0, 1'b0);
    send_beat(12'd60, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 16'h0 || out_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid_state got rdy=%b vld=%b sum=%h cnt=%0d required 0 0 0000 0",
               in_ready, out_valid, out_sum, out_count);
    end
    @(negedge clk); rst = 1'b0;
    send_beat(12'd1, 1'b0, 1'b1);
    checks++;
    if (out_sum !== 16'd1 || out_count !== 5'd1 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_result got sum=%h cnt=%0d ovf=%b required 0001 1 0", out_sum, out_count, out_ovf);
    end
    take_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_subtract();
    test_max_len();
    test_overflow();
    test_backpressure();
    test_idle_gap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
